// File: rtl/mac_pkg.sv
// Shared widths and helpers for the framed multiply-accumulate engine.
// The helpers work on 64-bit containers so one copy serves any parameterisation.
package mac_pkg;

  localparam int DEF_A_WIDTH   = 25;
  localparam int DEF_B_WIDTH   = 18;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_OUT_WIDTH = 24;
  localparam int DEF_OUT_SHIFT = 0;
  localparam int DEF_CNT_WIDTH = 10;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext64(input logic [63:0] v, input int w);
    return 64'($signed(v << (64 - w)) >>> (64 - w));
  endfunction

  // Clamp a 64-bit signed value into the signed w-bit range.
  function automatic logic [63:0] sat64(input logic [63:0] v, input int w);
    logic signed [63:0] sv;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sv = $signed(v);
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (sv > mx) return mx;
    if (sv < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/mac_out_conv.sv
// Combinational accumulator-to-result conversion: arithmetic shift, then wrap
// (default) or clamp with range flag when MAC_SAT_EN is defined.
module mac_out_conv
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic                 frame_ovf_i,
  output logic [OUT_WIDTH-1:0] out_o,
  output logic                 ovf_o
);

`ifdef MAC_SAT_EN
  logic [63:0] sh64;
  logic        rng;

  // Logical shift of the zero-padded value, re-signed from the surviving width.
  assign sh64  = sext64(64'(acc_i) >> OUT_SHIFT, ACC_WIDTH - OUT_SHIFT);
  assign rng   = (sext64(sh64, OUT_WIDTH) != sh64);
  assign out_o = OUT_WIDTH'(sat64(sh64, OUT_WIDTH));
  assign ovf_o = frame_ovf_i | rng;
`else
  assign out_o = OUT_WIDTH'($signed(acc_i) >>> OUT_SHIFT);
  assign ovf_o = frame_ovf_i;
`endif

endmodule

// File: rtl/mac_frame.sv
// Framed signed multiply-accumulate: S1 input regs, S2 product, S3 accumulate,
// S4 output regs. Optional clamping of the result under MAC_SAT_EN.
module mac_frame
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  output logic                 out_valid_o,
  output logic [OUT_WIDTH-1:0] out_o,
  output logic [CNT_WIDTH-1:0] out_cnt_o,
  output logic                 out_ovf_o
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH-1:0]   b_q;
  logic                        v1_q, l1_q;
  logic signed [PW-1:0]        prod_q;
  logic                        v2_q, l2_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        first_q;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        ovf_q;
  logic                        done_q;
  logic                        out_valid_q;
  logic [OUT_WIDTH-1:0]        out_q;
  logic [CNT_WIDTH-1:0]        out_cnt_q;
  logic                        out_ovf_q;

  logic signed [PW-1:0]        a_ext, b_ext;
  logic signed [ACC_WIDTH-1:0] prod_ext, sum_d;
  logic                        add_ovf;
  logic [OUT_WIDTH-1:0]        conv_out;
  logic                        conv_ovf;

  assign a_ext    = PW'(a_q);
  assign b_ext    = PW'(b_q);
  assign prod_ext = ACC_WIDTH'(sext64(64'(prod_q), PW));
  assign sum_d    = acc_q + prod_ext;
  // Signed overflow: operands agree in sign but the sum does not.
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  mac_out_conv #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_conv (
    .acc_i       (acc_q),
    .frame_ovf_i (ovf_q),
    .out_o       (conv_out),
    .ovf_o       (conv_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      l2_q        <= 1'b0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      // S1
      a_q  <= $signed(a_i);
      b_q  <= $signed(b_i);
      v1_q <= in_valid_i;
      l1_q <= in_valid_i & in_last_i;
      // S2
      prod_q <= a_ext * b_ext;
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      // S3: bubbles leave accumulator, count and flags untouched
      done_q <= v2_q & l2_q;
      if (v2_q) begin
        first_q <= l2_q;
        if (first_q) begin
          acc_q <= prod_ext;
          cnt_q <= CNT_WIDTH'(1);
          ovf_q <= 1'b0;
        end else begin
          acc_q <= sum_d;
          cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          ovf_q <= ovf_q | add_ovf;
        end
      end
      // S4
      out_valid_q <= done_q;
      if (done_q) begin
        out_q     <= conv_out;
        out_cnt_q <= cnt_q;
        out_ovf_q <= conv_ovf;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign out_cnt_o   = out_cnt_q;
  assign out_ovf_o   = out_ovf_q;

endmodule
